// File: rtl/tblink_rpc_rx_deframer.sv
// tblink_rpc_rx_deframer
// Strips the two-byte [dst][len-1] header from an 8-bit ready/valid byte
// stream and re-emits the payload through a single output register. Each
// output beat carries its own destination and last-byte flag, so the next
// packet's header can be consumed while the previous last beat is stalled.
// A wrapping 8-bit counter tracks packets whose last beat has drained.
module tblink_rpc_rx_deframer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_dat,
    input  logic                  i_valid,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_dat,
    output logic [7:0]            o_dst,
    output logic                  o_last,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [7:0]            pkt_count
);

    typedef enum logic [1:0] {
        ST_HDR_DST = 2'd0,
        ST_HDR_LEN = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            dst_q, dst_d;
    logic [7:0]            rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [7:0]            odst_q, odst_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;
    logic [7:0]            cnt_q, cnt_d;

    logic                  i_ready_s;
    logic                  in_xfer_s;
    logic                  out_xfer_s;

    // Input readiness: headers are always accepted; payload only when the
    // output register is empty or draining this cycle.
    always_comb begin
        i_ready_s = 1'b1;
        case (state_q)
            ST_HDR_DST: i_ready_s = 1'b1;
            ST_HDR_LEN: i_ready_s = 1'b1;
            ST_PAYLOAD: i_ready_s = !valid_q || o_ready;
            default:    i_ready_s = 1'b1;
        endcase
    end

    assign in_xfer_s  = i_valid && i_ready_s;
    assign out_xfer_s = valid_q && o_ready;

    // Next-state logic for the header/payload FSM, output register and
    // packet counter.
    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        dat_d   = dat_q;
        odst_d  = odst_q;
        last_d  = last_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        // Draining beat: count it if it closes a packet, empty the register
        // unless a new payload byte below refills it.
        if (out_xfer_s) begin
            valid_d = 1'b0;
            if (last_q) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            ST_HDR_DST: begin
                if (in_xfer_s) begin
                    dst_d   = i_dat[7:0];
                    state_d = ST_HDR_LEN;
                end else begin
                    state_d = ST_HDR_DST;
                end
            end
            ST_HDR_LEN: begin
                if (in_xfer_s) begin
                    rem_d   = i_dat[7:0];
                    state_d = ST_PAYLOAD;
                end else begin
                    state_d = ST_HDR_LEN;
                end
            end
            ST_PAYLOAD: begin
                if (in_xfer_s) begin
                    dat_d   = i_dat;
                    odst_d  = dst_q;
                    last_d  = (rem_q == 8'd0);
                    valid_d = 1'b1;
                    if (rem_q == 8'd0) begin
                        state_d = ST_HDR_DST;
                    end else begin
                        rem_d   = rem_q - 8'd1;
                        state_d = ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            default: begin
                state_d = ST_HDR_DST;
            end
        endcase
    end

    // State and output registers; asynchronous active-low reset discards
    // any partial packet and pending beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_HDR_DST;
            dst_q   <= 8'd0;
            rem_q   <= 8'd0;
            dat_q   <= {DATA_WIDTH{1'b0}};
            odst_q  <= 8'd0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            dat_q   <= dat_d;
            odst_q  <= odst_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign i_ready   = i_ready_s;
    assign o_dat     = dat_q;
    assign o_dst     = odst_q;
    assign o_last    = last_q;
    assign o_valid   = valid_q;
    assign pkt_count = cnt_q;

endmodule

// File: tb/tb_tblink_rpc_rx_deframer.sv
// Randomized bench for tblink_rpc_rx_deframer. Frames are generated as
// tagged byte lists; the reference keeps a queue of bytes still to send and
// a queue of payload beats accepted but not yet drained, and every cycle
// compares the DUT's handshake, beat contents and packet count against it.
module tb_tblink_rpc_rx_deframer;

    typedef struct {
        logic [7:0] dat;
        logic [7:0] dst;
        logic       last;
        logic       pay;
    } item_t;

    logic       clock;
    logic       reset;
    logic [7:0] i_dat;
    logic       i_valid;
    logic       i_ready;
    logic [7:0] o_dat;
    logic [7:0] o_dst;
    logic       o_last;
    logic       o_valid;
    logic       o_ready;
    logic [7:0] pkt_count;

    item_t      in_q[$];
    item_t      exp_q[$];
    item_t      log_q[$];
    logic [7:0] exp_cnt;
    int         n_checks;
    int         n_errors;
    int         cyc;
    int         first_valid_cyc;
    int         vld_pct;
    int         rdy_pct;
    int         stall_left;
    int         last_stall;
    bit         bp_arm;
    int         pay_acc;

    tblink_rpc_rx_deframer #(.DATA_WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .i_dat     (i_dat),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .o_dat     (o_dat),
        .o_dst     (o_dst),
        .o_last    (o_last),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .pkt_count (pkt_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [7:0] dst, input logic [7:0] lm1,
                              input logic [7:0] first, input bit incr);
        item_t it;
        it.dst = dst; it.last = 1'b0; it.pay = 1'b0;
        it.dat = dst;  in_q.push_back(it);
        it.dat = lm1;  in_q.push_back(it);
        for (int i = 0; i <= int'(lm1); i++) begin
            it.pay  = 1'b1;
            it.dat  = incr ? 8'(int'(first) + i) : 8'($urandom_range(255));
            it.last = (i == int'(lm1));
            in_q.push_back(it);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs
    // against the reference, then predict the transfers at the next rise.
    task automatic cycle();
        logic  r;
        bit    head_pay;
        bit    exp_irdy;
        bit    in_x;
        bit    out_x;
        item_t it;
        @(negedge clock);
        cyc++;
        r = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
        if (stall_left > 0) begin
            r = 1'b0; stall_left--;
        end else if (last_stall > 0 && exp_q.size() > 0 && exp_q[0].last) begin
            r = 1'b0; last_stall--;
        end else if (bp_arm && log_q.size() == 1 && exp_q.size() > 0) begin
            bp_arm = 1'b0; stall_left = 4; r = 1'b0;
        end
        o_ready = r;
        if (in_q.size() > 0 && (vld_pct >= 100 || $urandom_range(99) < vld_pct)) begin
            i_valid = 1'b1; i_dat = in_q[0].dat;
        end else begin
            i_valid = 1'b0; i_dat = 8'($urandom_range(255));
        end
        #1;
        head_pay = (in_q.size() > 0) ? in_q[0].pay : 1'b0;
        exp_irdy = head_pay ? (exp_q.size() == 0 || o_ready) : 1'b1;
        chk("i_ready", {31'd0, i_ready}, {31'd0, exp_irdy});
        chk("o_valid", {31'd0, o_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() > 0) begin
            chk("o_dat",  {24'd0, o_dat},  {24'd0, exp_q[0].dat});
            chk("o_dst",  {24'd0, o_dst},  {24'd0, exp_q[0].dst});
            chk("o_last", {31'd0, o_last}, {31'd0, exp_q[0].last});
        end
        chk("pkt_count", {24'd0, pkt_count}, {24'd0, exp_cnt});
        if (o_valid === 1'b1 && first_valid_cyc == 0) first_valid_cyc = cyc;
        out_x = (exp_q.size() > 0) && o_ready;
        in_x  = i_valid && exp_irdy;
        if (out_x) begin
            it = exp_q.pop_front();
            log_q.push_back(it);
            if (it.last) exp_cnt = exp_cnt + 8'd1;
        end
        if (in_x) begin
            it = in_q.pop_front();
            if (it.pay) begin
                exp_q.push_back(it);
                pay_acc++;
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        if (in_q.size() > 0 || exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: %0d bytes and %0d beats pending after %0d cycles",
                     in_q.size(), exp_q.size(), budget);
        end
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_o_valid",   {31'd0, o_valid},   32'd0);
        chk("rst_o_last",    {31'd0, o_last},    32'd0);
        chk("rst_o_dat",     {24'd0, o_dat},     32'd0);
        chk("rst_o_dst",     {24'd0, o_dst},     32'd0);
        chk("rst_pkt_count", {24'd0, pkt_count}, 32'd0);
        chk("rst_i_ready",   {31'd0, i_ready},   32'd1);
        in_q.delete();
        exp_q.delete();
        exp_cnt = 8'd0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int s;
        int nl;
        reset = 1'b1; i_valid = 1'b0; i_dat = 8'd0; o_ready = 1'b1;
        n_checks = 0; n_errors = 0; cyc = 0; exp_cnt = 8'd0;
        vld_pct = 100; rdy_pct = 100; stall_left = 0; last_stall = 0;
        bp_arm = 1'b0; pay_acc = 0; first_valid_cyc = 0;
        do_reset();

        // Basic packet
        log_q.delete(); first_valid_cyc = 0; s = cyc;
        push_frame(8'h03, 8'h02, 8'hA0, 1'b1);
        run_until_idle(50); cycle();
        chk("basic_nbeats", log_q.size(), 32'd3);
        for (int i = 0; i < 3 && i < log_q.size(); i++) begin
            chk("basic_dat",  {24'd0, log_q[i].dat},  32'hA0 + 32'(i));
            chk("basic_dst",  {24'd0, log_q[i].dst},  32'h03);
            chk("basic_last", {31'd0, log_q[i].last}, (i == 2) ? 32'd1 : 32'd0);
        end
        chk("basic_latency", first_valid_cyc - s, 32'd4);
        chk("basic_count", {24'd0, pkt_count}, 32'd1);

        // Single-byte packet
        log_q.delete();
        push_frame(8'h11, 8'h00, 8'h55, 1'b1);
        run_until_idle(50);
        chk("single_nbeats", log_q.size(), 32'd1);
        if (log_q.size() > 0) begin
            chk("single_dat",  {24'd0, log_q[0].dat},  32'h55);
            chk("single_last", {31'd0, log_q[0].last}, 32'd1);
        end

        // Maximum packet
        log_q.delete(); rdy_pct = 80; vld_pct = 90;
        push_frame(8'h22, 8'hFF, 8'h00, 1'b0);
        run_until_idle(2000);
        nl = 0;
        foreach (log_q[i]) if (log_q[i].last) nl++;
        chk("max_nbeats", log_q.size(), 32'd256);
        chk("max_nlast", nl, 32'd1);
        if (log_q.size() == 256) chk("max_last_pos", {31'd0, log_q[255].last}, 32'd1);

        // Backpressure mid-payload
        log_q.delete(); rdy_pct = 100; vld_pct = 100; bp_arm = 1'b1;
        push_frame(8'h33, 8'h07, 8'h10, 1'b1);
        run_until_idle(100);
        chk("bp_nbeats", log_q.size(), 32'd8);
        foreach (log_q[i]) chk("bp_dat", {24'd0, log_q[i].dat}, 32'h10 + 32'(i));

        // Back-to-back with stalled last beat
        log_q.delete(); last_stall = 4;
        push_frame(8'h01, 8'h02, 8'hB0, 1'b1);
        push_frame(8'h02, 8'h01, 8'hC0, 1'b1);
        run_until_idle(100);
        last_stall = 0;
        chk("b2b_nbeats", log_q.size(), 32'd5);
        foreach (log_q[i]) chk("b2b_dst", {24'd0, log_q[i].dst}, (i < 3) ? 32'h01 : 32'h02);

        // Reset mid-packet after two payload bytes
        push_frame(8'h05, 8'h03, 8'hD0, 1'b1);
        pay_acc = 0; s = 0;
        while (pay_acc < 2 && s < 50) begin cycle(); s++; end
        chk("midrst_accepted", pay_acc, 32'd2);
        do_reset();
        log_q.delete();
        push_frame(8'h07, 8'h00, 8'h99, 1'b1);
        run_until_idle(50); cycle();
        chk("post_rst_nbeats", log_q.size(), 32'd1);
        if (log_q.size() > 0) begin
            chk("post_rst_dat", {24'd0, log_q[0].dat}, 32'h99);
            chk("post_rst_dst", {24'd0, log_q[0].dst}, 32'h07);
        end
        chk("post_rst_count", {24'd0, pkt_count}, 32'd1);

        // Random frames with random valid/ready
        vld_pct = 70; rdy_pct = 60;
        for (int f = 0; f < 30; f++) begin
            push_frame(8'($urandom_range(255)),
                       ($urandom_range(9) == 0) ? 8'($urandom_range(60)) : 8'($urandom_range(7)),
                       8'd0, 1'b0);
        end
        run_until_idle(5000);

        // Counter wrap
        vld_pct = 100; rdy_pct = 100;
        do_reset();
        for (int f = 0; f < 257; f++) push_frame(8'(f), 8'h00, 8'(f), 1'b1);
        run_until_idle(2000); cycle();
        chk("wrap_count", {24'd0, pkt_count}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
